// File: rtl/lamp_bar_ctrl.sv
// Two-button lamp bar controller: synchronise, debounce and arbitrate inc/dec keys, drive a thermometer lamp bar.
// Define LAMP_BAR_BEEP_EN to build the wrap-around beep timer; otherwise buzzer is tied low.
module lamp_bar_ctrl #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int BEEP_CYC     = 5000000,
    parameter int LAMPS        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_inc_n,
    input  logic             key_dec_n,
    output logic [LAMPS-1:0] lamp,
    output logic [3:0]       level,
    output logic             click,
    output logic             buzzer
);
    localparam int             DW      = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    // The IDLE->COUNT cycle already saw the key low, so COUNT fires one count early.
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYC - 2);
    localparam logic [3:0]     LVL_MAX = 4'(LAMPS);

    typedef enum logic [1:0] {IDLE, COUNT, HELD} db_state_t;

    function automatic logic [LAMPS-1:0] thermo(input logic [3:0] lvl);
        logic [LAMPS-1:0] t;
        for (int i = 0; i < LAMPS; i++) begin
            t[i] = (4'(i) < lvl);
        end
        return t;
    endfunction

    logic [1:0] key_n;
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;
    logic [1:0] press;

    assign key_n = {key_dec_n, key_inc_n};

    // Stage p0/p1: two-flop synchroniser, bit 0 = inc, bit 1 = dec
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_db
        db_state_t     state;
        db_state_t     state_nxt;
        logic [DW-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (state == COUNT && cnt != DB_LAST) begin
                cnt <= cnt + 1'b1;
            end
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE:    if (!sync_p1[k]) state_nxt = COUNT;
                COUNT:   if (sync_p1[k]) state_nxt = IDLE;
                         else if (cnt == DB_LAST) state_nxt = HELD;
                HELD:    if (sync_p1[k]) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        assign press[k] = (state == COUNT) && !sync_p1[k] && (cnt == DB_LAST);
    end

    logic       do_inc;
    logic       do_dec;
    logic       wrap;
    logic       changed;
    logic [3:0] level_nxt;

    always_comb begin
        do_inc    = press[0] & ~press[1];
        do_dec    = press[1] & ~press[0];
        level_nxt = level;
        wrap      = 1'b0;
        changed   = 1'b0;
        if (do_inc) begin
            changed = 1'b1;
            if (level == LVL_MAX) begin
                level_nxt = '0;
                wrap      = 1'b1;
            end else begin
                level_nxt = level + 4'd1;
            end
        end else if (do_dec && level != 4'd0) begin
            changed   = 1'b1;
            level_nxt = level - 4'd1;
        end
    end

    // Output stage: level, lamp and click registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            lamp  <= '0;
            click <= 1'b0;
        end else begin
            level <= level_nxt;
            lamp  <= thermo(level_nxt);
            click <= changed;
        end
    end

`ifdef LAMP_BAR_BEEP_EN
    localparam int BW = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    logic [BW-1:0] beep_cnt;

    // beep_cnt holds the cycles remaining after the current one; a wrap reloads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt <= '0;
            buzzer   <= 1'b0;
        end else if (wrap) begin
            beep_cnt <= BW'(BEEP_CYC - 1);
            buzzer   <= 1'b1;
        end else if (beep_cnt != '0) begin
            beep_cnt <= beep_cnt - 1'b1;
        end else begin
            buzzer   <= 1'b0;
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = wrap;
    assign buzzer      = 1'b0;
`endif

endmodule

// File: tb/tb_lamp_bar_ctrl.sv
// Directed bench for lamp_bar_ctrl; buzzer expectations follow LAMP_BAR_BEEP_EN.
`timescale 1ns/1ps
module tb_lamp_bar_ctrl;
    localparam int D = 4;
    localparam int B = 6;
    localparam int L = 8;
`ifdef LAMP_BAR_BEEP_EN
    localparam bit BEEP_EN = 1'b1;
`else
    localparam bit BEEP_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         key_inc_n = 1'b1;
    logic         key_dec_n = 1'b1;
    logic [L-1:0] lamp;
    logic [3:0]   level;
    logic         click;
    logic         buzzer;

    // Second instance with a short debounce and one lamp so wraps can land inside a running beep
    logic         k2_inc_n = 1'b1;
    logic         k2_dec_n = 1'b1;
    logic [0:0]   lamp2;
    logic [3:0]   level2;
    logic         click2;
    logic         buzzer2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc, clicks, first_click, buz_cyc, first_buz;

    always #5 clk = ~clk;

    lamp_bar_ctrl #(.DEBOUNCE_CYC(D), .BEEP_CYC(B), .LAMPS(L)) dut (
        .clk(clk), .rst_n(rst_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .lamp(lamp), .level(level), .click(click), .buzzer(buzzer)
    );

    lamp_bar_ctrl #(.DEBOUNCE_CYC(2), .BEEP_CYC(10), .LAMPS(1)) u_fast (
        .clk(clk), .rst_n(rst_n), .key_inc_n(k2_inc_n), .key_dec_n(k2_dec_n),
        .lamp(lamp2), .level(level2), .click(click2), .buzzer(buzzer2)
    );

    task automatic clear_obs();
        cyc = 0; clicks = 0; first_click = 0; buz_cyc = 0; first_buz = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (click) begin
                clicks++;
                if (first_click == 0) first_click = cyc;
            end
            if (buzzer) begin
                buz_cyc++;
                if (first_buz == 0) first_buz = cyc;
            end
        end
    endtask

    task automatic press(input bit dec);
        if (dec) key_dec_n = 1'b0;
        else     key_inc_n = 1'b0;
        run(7);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        run(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(2);
    endtask

    task automatic test_reset();
        run(2);
        n_checks++; if (level !== 4'd0)  $display("FAIL reset_level: got %0d expected 0", level);  else n_pass++;
        n_checks++; if (lamp !== 8'h00)  $display("FAIL reset_lamp: got %h expected 00", lamp);    else n_pass++;
        n_checks++; if (click !== 1'b0)  $display("FAIL reset_click: got %b expected 0", click);   else n_pass++;
        n_checks++; if (buzzer !== 1'b0) $display("FAIL reset_buzzer: got %b expected 0", buzzer); else n_pass++;
        rst_n = 1'b1;
        run(3);
        n_checks++; if (level !== 4'd0)  $display("FAIL idle_level: got %0d expected 0", level);   else n_pass++;
    endtask

    task automatic test_glitch();
        clear_obs();
        for (int g = 0; g < 5; g++) begin
            key_inc_n = 1'b0; run(2);
            key_inc_n = 1'b1; run(3);
        end
        // one cycle short of the debounce window
        key_inc_n = 1'b0; run(3);
        key_inc_n = 1'b1; run(3);
        n_checks++; if (clicks != 0)    $display("FAIL glitch_clicks: got %0d expected 0", clicks); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL glitch_level: got %0d expected 0", level);   else n_pass++;
        n_checks++; if (lamp !== 8'h00) $display("FAIL glitch_lamp: got %h expected 00", lamp);     else n_pass++;
    endtask

    task automatic test_single_inc();
        clear_obs();
        key_inc_n = 1'b0; run(10);
        key_inc_n = 1'b1; run(3);
        n_checks++; if (clicks != 1)      $display("FAIL single_clicks: got %0d expected 1", clicks);       else n_pass++;
        n_checks++; if (first_click != 6) $display("FAIL single_latency: got %0d expected 6", first_click); else n_pass++;
        n_checks++; if (level !== 4'd1)   $display("FAIL single_level: got %0d expected 1", level);         else n_pass++;
        n_checks++; if (lamp !== 8'h01)   $display("FAIL single_lamp: got %h expected 01", lamp);           else n_pass++;
        n_checks++; if (buz_cyc != 0)     $display("FAIL single_buzzer: got %0d expected 0", buz_cyc);      else n_pass++;
    endtask

    task automatic test_held_through_reset();
        key_inc_n = 1'b0;
        rst_n     = 1'b0;
        run(2);
        clear_obs();
        rst_n = 1'b1;
        run(9);
        key_inc_n = 1'b1;
        run(3);
        n_checks++; if (clicks != 1)      $display("FAIL held_rst_clicks: got %0d expected 1", clicks);       else n_pass++;
        n_checks++; if (first_click != 6) $display("FAIL held_rst_latency: got %0d expected 6", first_click); else n_pass++;
        n_checks++; if (level !== 4'd1)   $display("FAIL held_rst_level: got %0d expected 1", level);         else n_pass++;
    endtask

    task automatic test_wrap();
        int         tot;
        logic [3:0] exp_lvl;
        logic [8:0] t;
        logic [7:0] exp_lamp;
        do_reset();
        tot = 0;
        for (int p = 0; p < 9; p++) begin
            clear_obs();
            press(1'b0);
            tot += clicks;
            exp_lvl  = 4'((p + 1) % 9);
            t        = (9'd1 << exp_lvl) - 9'd1;
            exp_lamp = t[7:0];
            n_checks++; if (level !== exp_lvl) $display("FAIL wrap_level[%0d]: got %0d expected %0d", p, level, exp_lvl); else n_pass++;
            n_checks++; if (lamp !== exp_lamp) $display("FAIL wrap_lamp[%0d]: got %h expected %h", p, lamp, exp_lamp);    else n_pass++;
        end
        n_checks++; if (first_buz != (BEEP_EN ? 6 : 0)) $display("FAIL wrap_buzzer_rise: got %0d expected %0d", first_buz, BEEP_EN ? 6 : 0); else n_pass++;
        run(5);
        n_checks++; if (buz_cyc != (BEEP_EN ? B : 0)) $display("FAIL wrap_buzzer_len: got %0d expected %0d", buz_cyc, BEEP_EN ? B : 0); else n_pass++;
        n_checks++; if (buzzer !== 1'b0) $display("FAIL wrap_buzzer_off: got %b expected 0", buzzer); else n_pass++;
        n_checks++; if (tot != 9)        $display("FAIL wrap_clicks: got %0d expected 9", tot);       else n_pass++;
    endtask

    task automatic test_dec_saturate();
        int tot;
        clear_obs();
        press(1'b1);
        n_checks++; if (clicks != 0)    $display("FAIL sat_clicks: got %0d expected 0", clicks); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL sat_level: got %0d expected 0", level);   else n_pass++;
        clear_obs();
        press(1'b0);
        tot = clicks;
        n_checks++; if (level !== 4'd1) $display("FAIL incdec_level_up: got %0d expected 1", level); else n_pass++;
        clear_obs();
        press(1'b1);
        tot += clicks;
        n_checks++; if (level !== 4'd0) $display("FAIL incdec_level_down: got %0d expected 0", level); else n_pass++;
        n_checks++; if (lamp !== 8'h00) $display("FAIL incdec_lamp: got %h expected 00", lamp);       else n_pass++;
        n_checks++; if (tot != 2)       $display("FAIL incdec_clicks: got %0d expected 2", tot);      else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_obs();
        key_inc_n = 1'b0;
        key_dec_n = 1'b0;
        run(10);
        n_checks++; if (clicks != 0)    $display("FAIL both_clicks: got %0d expected 0", clicks); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL both_level: got %0d expected 0", level);   else n_pass++;
        key_dec_n = 1'b1;
        run(6);
        n_checks++; if (clicks != 0)    $display("FAIL held_no_repeat: got %0d expected 0", clicks); else n_pass++;
        key_inc_n = 1'b1;
        run(3);
        clear_obs();
        press(1'b0);
        n_checks++; if (clicks != 1)    $display("FAIL repress_clicks: got %0d expected 1", clicks); else n_pass++;
        n_checks++; if (level !== 4'd1) $display("FAIL repress_level: got %0d expected 1", level);   else n_pass++;
    endtask

    // Key pattern L L H repeating gives a press pulse every 3 edges: 0->1 at 3, wrap at 6, 0->1 at 9, wrap at 12.
    task automatic test_restart();
        bit         lo;
        bit         exp_b;
        logic [3:0] exp_l;
        for (int j = 0; j < 30; j++) begin
            lo       = (j < 11) && (j % 3 != 2);
            k2_inc_n = !lo;
            @(negedge clk);
            exp_b = BEEP_EN && (j >= 6) && (j <= 21);
            n_checks++; if (buzzer2 !== exp_b) $display("FAIL restart_buzzer[%0d]: got %b expected %b", j, buzzer2, exp_b); else n_pass++;
            if (j == 3 || j == 6 || j == 9 || j == 12) begin
                exp_l = (j == 3 || j == 9) ? 4'd1 : 4'd0;
                n_checks++; if (level2 !== exp_l) $display("FAIL restart_level[%0d]: got %0d expected %0d", j, level2, exp_l); else n_pass++;
                n_checks++; if (click2 !== 1'b1) $display("FAIL restart_click[%0d]: got %b expected 1", j, click2); else n_pass++;
            end
        end
        k2_inc_n = 1'b1;
    endtask

    task automatic test_async_reset();
        for (int j = 0; j < 10; j++) begin
            k2_inc_n = !((j % 3) != 2);
            @(negedge clk);
        end
        n_checks++; if (level2 !== 4'd1)   $display("FAIL pre_rst_level2: got %0d expected 1", level2);           else n_pass++;
        n_checks++; if (buzzer2 !== BEEP_EN) $display("FAIL pre_rst_buzzer2: got %b expected %b", buzzer2, BEEP_EN); else n_pass++;
        n_checks++; if (level !== 4'd1)    $display("FAIL pre_rst_level: got %0d expected 1", level);             else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (buzzer2 !== 1'b0) $display("FAIL async_buzzer2: got %b expected 0", buzzer2); else n_pass++;
        n_checks++; if (level2 !== 4'd0)  $display("FAIL async_level2: got %0d expected 0", level2); else n_pass++;
        n_checks++; if (lamp2 !== 1'b0)   $display("FAIL async_lamp2: got %b expected 0", lamp2);    else n_pass++;
        n_checks++; if (level !== 4'd0)   $display("FAIL async_level: got %0d expected 0", level);   else n_pass++;
        n_checks++; if (lamp !== 8'h00)   $display("FAIL async_lamp: got %h expected 00", lamp);     else n_pass++;
        k2_inc_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run(2);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_inc();
        test_held_through_reset();
        test_wrap();
        test_dec_saturate();
        test_back_to_back();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
